// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined carry-lookahead adder (bit G/P, group lookahead, sum) with valid/ready flow.
// Optional signed-overflow output Ovf is enabled by defining CLA_OVF_FLAG_EN.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co
`ifdef CLA_OVF_FLAG_EN
  ,
  output logic             Ovf
`endif
);

  localparam int NG = WIDTH / GROUP;

  generate
    if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
    end
  endgenerate

  logic             r_v1, r_v2, r_v3;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_ci;
  logic [WIDTH-1:0] r_p2, r_g2;
  logic [NG:0]      r_cg2;
  logic [WIDTH-1:0] r_s;
  logic             r_co;

  logic             w_ld1, w_ld2, w_ld3;
  logic [WIDTH-1:0] w_g1, w_p1;
  logic [NG-1:0]    w_gg, w_gp;
  logic [NG:0]      w_cg;
  logic [WIDTH-1:0] w_c, w_sum;
  logic             w_unused_gtop;

  // A stage may load when it is empty or its contents leave this cycle.
  assign w_ld3    = !r_v3 || out_ready;
  assign w_ld2    = !r_v2 || w_ld3;
  assign w_ld1    = !r_v1 || w_ld2;
  assign in_ready = w_ld1 && !rst;

  assign w_g1 = r_a & r_b;
  assign w_p1 = r_a ^ r_b;

  always_comb begin
    w_gg  = '0;
    w_gp  = '1;
    w_cg  = '0;
    w_cg[0] = r_ci;
    for (int unsigned j = 0; j < NG; j++) begin
      for (int unsigned k = 0; k < GROUP; k++) begin
        w_gg[j] = w_g1[j*GROUP+k] | (w_p1[j*GROUP+k] & w_gg[j]);
        w_gp[j] = w_gp[j] & w_p1[j*GROUP+k];
      end
      w_cg[j+1] = w_gg[j] | (w_gp[j] & w_cg[j]);
    end
  end

  // Ripple inside each group from its lookahead carry; group-top g is subsumed by r_cg2.
  always_comb begin
    w_c           = '0;
    w_unused_gtop = 1'b0;
    for (int unsigned j = 0; j < NG; j++) begin
      w_c[j*GROUP] = r_cg2[j];
      for (int unsigned k = 1; k < GROUP; k++) begin
        w_c[j*GROUP+k] = r_g2[j*GROUP+k-1] | (r_p2[j*GROUP+k-1] & w_c[j*GROUP+k-1]);
      end
      w_unused_gtop = w_unused_gtop ^ r_g2[j*GROUP+GROUP-1];
    end
  end

  assign w_sum = r_p2 ^ w_c;

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      r_a  <= A;
      r_b  <= B;
      r_ci <= Ci;
    end
    if (w_ld2 && r_v1) begin
      r_p2  <= w_p1;
      r_g2  <= w_g1;
      r_cg2 <= w_cg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_s  <= '0;
      r_co <= 1'b0;
    end else begin
      if (w_ld1) r_v1 <= in_valid;
      if (w_ld2) r_v2 <= r_v1;
      if (w_ld3) r_v3 <= r_v2;
      if (w_ld3 && r_v2) begin
        r_s  <= w_sum;
        r_co <= r_cg2[NG];
      end
    end
  end

  assign out_valid = r_v3;
  assign S         = r_s;
  assign Co        = r_co;

`ifdef CLA_OVF_FLAG_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ld3 && r_v2) begin
      r_ovf <= w_c[WIDTH-1] ^ r_cg2[NG];
    end
  end

  assign Ovf = r_ovf;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed cases plus random traffic against an arithmetic scoreboard.
// Define CLA_OVF_FLAG_EN for both files to exercise the Ovf output.
module tb_cla_pipe_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Ci = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] S;
  logic         Co;
  logic         ovf_obs;

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Ci        (Ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Co        (Co)
`ifdef CLA_OVF_FLAG_EN
    ,
    .Ovf       (ovf_obs)
`endif
  );

`ifndef CLA_OVF_FLAG_EN
  assign ovf_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [W+1:0] exp_q[$];
  int unsigned  tick_no  = 0;
  int unsigned  n_out    = 0;
  int unsigned  gaps     = 0;
  int unsigned  last_out = 0;
  bit           hold_prev = 1'b0;
  logic [W-1:0] s_prev;
  logic         co_prev;
  logic         ovf_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {ovf, co, sum}: plain integer addition plus the signed-overflow rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] sum;
    logic       ovf;
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    return {ovf, sum};
  endfunction

  // Sample handshakes mid-cycle, then advance one clock and return at the falling edge.
  task automatic tick();
    logic [W+1:0] e;
    #1;
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_S", S, s_prev);
        chk("stall_Co", Co, co_prev);
`ifdef CLA_OVF_FLAG_EN
        chk("stall_Ovf", ovf_obs, ovf_prev);
`endif
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, Ci));
      if (out_valid && out_ready) begin
        chk("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sum", S, e[W-1:0]);
          chk("co", Co, e[W]);
`ifdef CLA_OVF_FLAG_EN
          chk("ovf", ovf_obs, e[W+1]);
`endif
        end
        if (n_out != 0 && tick_no != last_out + 1) gaps++;
        last_out = tick_no;
        n_out++;
      end
      hold_prev = out_valid && !out_ready;
      s_prev    = S;
      co_prev   = Co;
      ovf_prev  = ovf_obs;
    end
    @(posedge clk);
    @(negedge clk);
    tick_no++;
  endtask

  // Send one word into an idle pipe, measure latency, check pulse width; returns observed result.
  task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          output logic [W-1:0] s_o, output logic co_o, output logic ovf_o);
    int unsigned lat;
    out_ready = 1'b1;
    A = a; B = b; Ci = ci; in_valid = 1'b1;
    chk("one_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("one_latency", lat, 3);
    s_o = S; co_o = Co; ovf_o = ovf_obs;
    tick();
    chk("one_pulse_width", out_valid, 0);
  endtask

  logic [W-1:0] s_o;
  logic         co_o, ovf_o;
  logic [W+1:0] e_first;
  int unsigned  acc;
  int unsigned  guard;

  initial begin
    // Reset
    tick();
    chk("rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_S", S, 0);
    chk("rst_Co", Co, 0);
    chk("rst_in_ready_after", in_ready, 1);
    @(negedge clk);

    send_one(16'h1234, 16'h4321, 1'b0, s_o, co_o, ovf_o);
    chk("dir_1234_S", s_o, 16'h5555);
    chk("dir_1234_Co", co_o, 0);

    send_one(16'hFFFF, 16'h0000, 1'b1, s_o, co_o, ovf_o);
    chk("ripple_S", s_o, 16'h0000);
    chk("ripple_Co", co_o, 1);
`ifdef CLA_OVF_FLAG_EN
    chk("ripple_Ovf", ovf_o, 0);
    send_one(16'h7FFF, 16'h0001, 1'b0, s_o, co_o, ovf_o);
    chk("ovf_pos_S", s_o, 16'h8000);
    chk("ovf_pos_Co", co_o, 0);
    chk("ovf_pos_Ovf", ovf_o, 1);
    send_one(16'h8000, 16'h8000, 1'b0, s_o, co_o, ovf_o);
    chk("ovf_neg_S", s_o, 16'h0000);
    chk("ovf_neg_Co", co_o, 1);
    chk("ovf_neg_Ovf", ovf_o, 1);
`endif

    // Back-to-back stream
    n_out = 0; gaps = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      A = W'(i); B = W'(i * 3); Ci = i[0]; in_valid = 1'b1;
      #1 chk("stream_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    guard = 0;
    while (n_out < 8 && guard < 10) begin tick(); guard++; end
    chk("stream_count", n_out, 8);
    chk("stream_gaps", gaps, 0);

    // Backpressure
    n_out = 0;
    out_ready = 1'b0;
    acc = 0;
    e_first = model(16'h1000, 16'h0F0F, 1'b1);
    for (int i = 0; i < 6; i++) begin
      A = W'(16'h1000 + acc); B = W'(16'h0F0F * (acc + 1)); Ci = ~acc[0]; in_valid = 1'b1;
      #1 if (in_ready) acc++;
      tick();
    end
    chk("bp_accepts", acc, 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_hold_S", S, e_first[W-1:0]);
    out_ready = 1'b1;
    guard = 0;
    while (acc < 5 && guard < 10) begin
      A = W'(16'h1000 + acc); B = W'(16'h0F0F * (acc + 1)); Ci = ~acc[0]; in_valid = 1'b1;
      #1 if (in_ready) acc++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (n_out < 5 && guard < 10) begin tick(); guard++; end
    chk("bp_drained", n_out, 5);

    // Mid-flight reset
    n_out = 0;
    for (int i = 0; i < 2; i++) begin
      A = W'(16'hA5A5 + i); B = 16'h0101; Ci = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_S", S, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_rst_discarded", n_out, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      A = W'($urandom); B = W'($urandom); Ci = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin tick(); guard++; end
    chk("rand_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
